operand_loader: RTL and testbench
=================================

# operand_loader

Upstream feeder for the approximate-multiplier controller/datapath. Accepts operand pairs on a valid/ready stream, writes them into the operand RAM, and hands a full frame of `DEPTH` pairs to the multiplier with a one-cycle `Start` pulse. It then blocks further input until the multiplier returns `Done`, so a frame in flight is never overwritten.

## Interface
Parameters:
- `DATA_W`, 16: width of each operand.
- `ADDR_W`, 4: RAM address width.
- `DEPTH`, 16: pairs per frame; `DEPTH` ≤ 2^`ADDR_W` and `DEPTH` ≥ 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair present.
- `in_a`  in  `DATA_W`  first operand.
- `in_b`  in  `DATA_W`  second operand.
- `in_ready`  out  1  loader accepts a pair this cycle.
- `mem_wr`  out  1  RAM write strobe, registered.
- `mem_addr`  out  `ADDR_W`  RAM write address, registered.
- `mem_din_a`  out  `DATA_W`  operand A word for the RAM, registered.
- `mem_din_b`  out  `DATA_W`  operand B word for the RAM, registered.
- `Start`  out  1  one-cycle frame-start pulse to the multiplier controller.
- `Done`  in  1  one-cycle frame-complete pulse from the multiplier controller.
- `busy`  out  1  high from `Start` until `Done` is accepted.

## Operation
- FSM states: `IDLE`, `FILL`, `FLUSH`, `START`, `WAIT_DONE`.
- `IDLE`: entered on reset. Goes to `FILL` on the next clock, unconditionally.
- `FILL`:
  - `in_ready` = 1.
  - Handshake is `in_valid & in_ready`. On a handshake, the pair and the write pointer `wptr` are registered onto `mem_din_a`, `mem_din_b`, `mem_addr`, and `mem_wr` = 1 on the next cycle.
  - `wptr` increments on each handshake.
  - On the handshake with `wptr` = `DEPTH`-1, go to `FLUSH` and clear `wptr` to 0.
- `FLUSH`: `in_ready` = 0. Lasts one cycle, during which the final `mem_wr` is issued. Go to `START`.
- `START`: `Start` = 1 for exactly one cycle, then go to `WAIT_DONE`. The controller latches on `Start` high and begins when `Start` returns low.
- `WAIT_DONE`: `in_ready` = 0 and `busy` = 1. On `Done` = 1, go to `FILL`.
- `Done` in any state other than `WAIT_DONE` is ignored.
- `in_a` and `in_b` are ignored while `in_ready` = 0. A pending `in_valid` is held by the source and is not lost.
- `wptr` is never out of range: it wraps to 0 exactly at `DEPTH`-1, also when `DEPTH` < 2^`ADDR_W`.
- `mem_din_a`, `mem_din_b` and `mem_addr` hold their last values when `mem_wr` = 0.

## Timing
- Reset values:
  - `in_ready`, `mem_wr`, `Start`, `busy` = 0.
  - `mem_addr`, `mem_din_a`, `mem_din_b` = 0.
  - `wptr` = 0, state = `IDLE`.
- Reset asserted mid-frame: the partial frame is discarded; after deassertion the loader refills from address 0.
- Throughput: one pair per cycle in `FILL`.
- Write latency: handshake at cycle t gives `mem_wr` at t+1.
- Last handshake at t:
  - last `mem_wr` at t+1 (`FLUSH`);
  - `Start` at t+2;
  - `busy` from t+2.
- `Done` sampled at cycle d: `busy` = 0 and `in_ready` = 1 at d+1. The earliest new `mem_wr` is at d+2.
- No combinational path from any input to any output except `in_ready`, which is decoded from state only.

## Configuration
- `LOADER_FRAME_CNT_EN`:
  - When defined, adds output `frame_cnt` [7:0]. Reset value 0; increments on each `Done` accepted in `WAIT_DONE`; wraps 255→0.
  - When undefined, the port and its counter are absent. All other behaviour is identical.

## Test plan
- Reset then `DEPTH`=16 back-to-back pairs (A=i+1, B=2i+1) -> `mem_wr` at addresses 0..15 in order with matching data; one `Start` pulse two cycles after the 16th handshake; `busy`=1.
- `in_valid` toggled every other cycle during fill -> exactly 16 writes, no duplicates or gaps, single `Start`.
- `in_valid` held high during `WAIT_DONE` for 50 cycles -> `in_ready`=0, no `mem_wr`; `Done` pulse -> `in_ready`=1 next cycle and the held pair is written to address 0.
- Spurious `Done` during `FILL` at entry 5 -> ignored; fill continues to 15 and `Start` fires normally.
- `rst` low asynchronously while filling at entry 9 -> all outputs 0 immediately; after release, the next write goes to address 0.
- With `LOADER_FRAME_CNT_EN`, run 3 frames -> `frame_cnt`=3; after 256 frames -> 0.

Source files
------------

// File: rtl/operand_loader.sv
// -----------------------------------------------------------------------------
// operand_loader
//
// Upstream feeder for the approximate-multiplier controller/datapath. Operand
// pairs arrive on a valid/ready stream and are written into the operand RAM.
// After a full frame of DEPTH pairs is written, the loader pulses Start for one
// cycle. It then holds off further input until the multiplier returns Done, so
// a frame in flight is never overwritten.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   in_valid   in   operand pair present
//   in_a/in_b  in   operands (DATA_W)
//   in_ready   out  loader accepts a pair this cycle (decoded from state only)
//   mem_wr     out  registered RAM write strobe
//   mem_addr   out  registered RAM write address (ADDR_W)
//   mem_din_a  out  registered operand A word (DATA_W)
//   mem_din_b  out  registered operand B word (DATA_W)
//   Start      out  one-cycle frame-start pulse
//   Done       in   one-cycle frame-complete pulse (only honoured in WAIT_DONE)
//   busy       out  high from Start until Done is accepted
//   frame_cnt  out  [7:0] completed-frame counter, present only with
//                   LOADER_FRAME_CNT_EN defined
//
// Optional feature macro: LOADER_FRAME_CNT_EN
// Parameter constraint: 1 <= DEPTH <= 2**ADDR_W.
// -----------------------------------------------------------------------------
module operand_loader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              in_ready,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din_a,
    output logic [DATA_W-1:0] mem_din_b,
    output logic              Start,
    input  logic              Done,
    output logic              busy
`ifdef LOADER_FRAME_CNT_EN
    ,
    output logic [7:0]        frame_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FILL      = 3'd1,
        FLUSH     = 3'd2,
        START     = 3'd3,
        WAIT_DONE = 3'd4
    } state_e;

    // Wrap point for the write pointer; supports frames shorter than the RAM.
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wptr_q, wptr_d;
    logic                wr_en_s;
    logic                mem_wr_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   din_a_q, din_b_q;
    logic                start_q, busy_q;

    // Next-state, write-pointer and handshake decode.
    always_comb begin
        state_d  = state_q;
        wptr_d   = wptr_q;
        in_ready = 1'b0;
        wr_en_s  = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = FILL;
            end
            FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_en_s = 1'b1;
                    if (wptr_q == LAST_PTR) begin
                        wptr_d  = {ADDR_W{1'b0}};
                        state_d = FLUSH;
                    end else begin
                        wptr_d = wptr_q + ADDR_W'(1);
                    end
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            FLUSH: begin
                // Final mem_wr of the frame is on the bus during this cycle.
                state_d = START;
            end
            START: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (Done) begin
                    state_d = FILL;
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and write-pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wptr_q  <= {ADDR_W{1'b0}};
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
        end
    end

    // RAM write port; address/data hold their last values between writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_wr_q   <= 1'b0;
            mem_addr_q <= {ADDR_W{1'b0}};
            din_a_q    <= {DATA_W{1'b0}};
            din_b_q    <= {DATA_W{1'b0}};
        end else begin
            mem_wr_q <= wr_en_s;
            if (wr_en_s) begin
                mem_addr_q <= wptr_q;
                din_a_q    <= in_a;
                din_b_q    <= in_b;
            end
        end
    end

    // Start/busy are registered from the next state so they align with the
    // START and WAIT_DONE states without any input-to-output path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            start_q <= (state_d == START);
            busy_q  <= (state_d == START) || (state_d == WAIT_DONE);
        end
    end

    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din_a = din_a_q;
    assign mem_din_b = din_b_q;
    assign Start     = start_q;
    assign busy      = busy_q;

`ifdef LOADER_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    // Completed-frame counter; wraps naturally at 8 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q <= 8'd0;
        end else if ((state_q == WAIT_DONE) && Done) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_operand_loader.sv
module tb_operand_loader;

    localparam int DW  = 16;
    localparam int AW  = 4;
    localparam int DEP = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic          in_ready;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din_a;
    logic [DW-1:0] mem_din_b;
    logic          Start;
    logic          Done = 1'b0;
    logic          busy;
`ifdef LOADER_FRAME_CNT_EN
    logic [7:0]    frame_cnt;
`endif

    operand_loader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ready  (in_ready),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_din_a (mem_din_a),
        .mem_din_b (mem_din_b),
        .Start     (Start),
        .Done      (Done),
        .busy      (busy)
`ifdef LOADER_FRAME_CNT_EN
        ,
        .frame_cnt (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } wr_t;

    int   tests = 0;
    int   fails = 0;
    wr_t  wq[$];
    int   sq[$];
    int   cyc = 0;
    // Reference model state: pairs accepted since reset, frame-full flag.
    int   n_acc = 0;
    bit   full = 1'b0;
    int   full_c = 0;
    bit   m_ready = 1'b0;
    int   frames = 0;
    logic [DW-1:0] held_a, held_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: frame of DEP pairs, then blocked until a Done seen at
    // least three cycles after the last accepted pair.
    initial begin
        wr_t e;
        int  c;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                wq.delete();
                sq.delete();
                full    = 1'b0;
                m_ready = 1'b0;
                n_acc   = 0;
                frames  = 0;
            end else begin
                c = cyc;
                if (in_valid && m_ready) begin
                    e.cyc  = c + 1;
                    e.addr = AW'(n_acc % DEP);
                    e.a    = in_a;
                    e.b    = in_b;
                    wq.push_back(e);
                    n_acc++;
                    if (n_acc % DEP == 0) begin
                        full   = 1'b1;
                        full_c = c;
                        sq.push_back(c + 2);
                    end
                end else if (full && Done && c >= full_c + 3) begin
                    full = 1'b0;
                    frames++;
                end
                m_ready = !full;
                cyc     = c + 1;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a write or Start.
    initial begin
        wr_t e;
        logic [AW-1:0] last_addr;
        logic [DW-1:0] last_a, last_b;
        last_addr = '0; last_a = '0; last_b = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                last_addr = '0; last_a = '0; last_b = '0;
                chk("rst_outputs", {26'd0, in_ready, mem_wr, Start, busy,
                    |mem_addr, |{mem_din_a, mem_din_b}}, 32'd0);
            end else begin
                if (mem_wr) begin
                    if (wq.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_write: got addr %0h expected no write (cycle %0d)", mem_addr, cyc);
                    end else begin
                        e = wq.pop_front();
                        chk("wr_cycle", 32'(cyc), 32'(e.cyc));
                        chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                        chk("wr_a", 32'(mem_din_a), 32'(e.a));
                        chk("wr_b", 32'(mem_din_b), 32'(e.b));
                        last_addr = e.addr; last_a = e.a; last_b = e.b;
                    end
                end else begin
                    if (wq.size() > 0 && wq[0].cyc <= cyc) begin
                        e = wq.pop_front();
                        tests++; fails++;
                        $display("FAIL missing_write: got none expected addr %0h at cycle %0d", e.addr, e.cyc);
                    end
                    chk("hold_addr", 32'(mem_addr), 32'(last_addr));
                    chk("hold_data", {mem_din_a, mem_din_b}, {last_a, last_b});
                end
                if (Start) begin
                    if (sq.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_start: got 1 expected 0 (cycle %0d)", cyc);
                    end else begin
                        chk("start_cycle", 32'(cyc), 32'(sq.pop_front()));
                    end
                end else if (sq.size() > 0 && sq[0] <= cyc) begin
                    tests++; fails++;
                    $display("FAIL missing_start: got 0 expected 1 at cycle %0d", sq.pop_front());
                end
                chk("in_ready", 32'(in_ready), 32'(m_ready));
                chk("busy", 32'(busy), 32'(full && cyc >= full_c + 2));
`ifdef LOADER_FRAME_CNT_EN
                chk("frame_cnt", 32'(frame_cnt), 32'(frames % 256));
`endif
            end
        end
    end

    // Drive one frame. det: A=i+1,B=2i+1; toggle: idle cycle before each pair;
    // held: item 0 uses held_a/held_b; spur_at: Done pulse alongside that item;
    // rst_at: assert reset asynchronously while presenting that item.
    task automatic drive_frame(input bit det, input bit toggle, input bit held,
                               input int spur_at, input int rst_at);
        bit acc;
        int guard;
        for (int i = 0; i < DEP; i++) begin
            if (toggle && !(held && i == 0)) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            if (held && i == 0) begin
                in_a = held_a; in_b = held_b;
            end else if (det) begin
                in_a = DW'(i + 1); in_b = DW'(2 * i + 1);
            end else begin
                in_a = DW'($urandom); in_b = DW'($urandom);
            end
            in_valid = 1'b1;
            if (i == spur_at) Done = 1'b1;
            if (i == rst_at) begin
                #2 rst = 1'b0;
                #1;
                chk("async_rst_mem_wr", 32'(mem_wr), 32'd0);
                chk("async_rst_ready", 32'(in_ready), 32'd0);
                chk("async_rst_addr", 32'(mem_addr), 32'd0);
                chk("async_rst_data", {mem_din_a, mem_din_b}, 32'd0);
                chk("async_rst_start_busy", {30'd0, Start, busy}, 32'd0);
                in_valid = 1'b0;
                Done = 1'b0;
                return;
            end
            guard = 0;
            do begin
                @(negedge clk);
                acc = in_valid && in_ready;
                @(posedge clk); #1;
                Done = 1'b0;
                guard++;
            end while (!acc && guard < 100);
            if (!acc) begin
                tests++; fails++;
                $display("FAIL handshake_timeout: got no accept expected accept of item %0d", i);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic finish_frame();
        repeat (3) begin @(posedge clk); #1; end
        Done = 1'b1;
        @(posedge clk); #1;
        Done = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Frame 1: deterministic back-to-back pairs.
        drive_frame(1'b1, 1'b0, 1'b0, -1, -1);
        @(posedge clk); #1;
        chk("start_pulse", 32'(Start), 32'd1);
        chk("busy_at_start", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("start_single", 32'(Start), 32'd0);
        chk("busy_wait", 32'(busy), 32'd1);

        // Source holds a pair for 50 cycles while blocked.
        held_a = DW'($urandom); held_b = DW'($urandom);
        in_a = held_a; in_b = held_b; in_valid = 1'b1;
        repeat (50) begin @(posedge clk); #1; end
        chk("blocked_ready", 32'(in_ready), 32'd0);
        Done = 1'b1;
        @(posedge clk); #1;
        Done = 1'b0;
        chk("ready_after_done", 32'(in_ready), 32'd1);
        chk("busy_after_done", 32'(busy), 32'd0);

        // Frame 2: held pair first, then valid toggled every other cycle.
        drive_frame(1'b0, 1'b1, 1'b1, -1, -1);
        finish_frame();

        // Frame 3: spurious Done while filling at entry 5.
        drive_frame(1'b0, 1'b0, 1'b0, 5, -1);
        finish_frame();

        // Frame 4: async reset at entry 9, then refill from address 0.
        drive_frame(1'b0, 1'b0, 1'b0, -1, 9);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        for (int f = 0; f < 3; f++) begin
            drive_frame(1'b0, 1'b0, 1'b0, -1, -1);
            finish_frame();
        end
`ifdef LOADER_FRAME_CNT_EN
        chk("frame_cnt_3", 32'(frame_cnt), 32'd3);
        for (int f = 0; f < 253; f++) begin
            drive_frame(1'b0, 1'b0, 1'b0, -1, -1);
            finish_frame();
        end
        chk("frame_cnt_wrap", 32'(frame_cnt), 32'd0);
`endif

        repeat (5) begin @(posedge clk); #1; end
        chk("writes_drained", 32'(wq.size()), 32'd0);
        chk("starts_drained", 32'(sq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
